key_event_queue: RTL and testbench
==================================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Sits between the tm1638_driver `buttons` output and the SBC6502 input port. It debounces the keys, turns press/release edges into event codes, and queues them for the CPU.

Interface
REQ-001 SHALL have parameter SYSCLK_MHZ, default 50: system clock frequency in MHz; one tick = SYSCLK_MHZ*1000 clocks (1 ms).
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, range 1..15: consecutive ticks a key must differ from its debounced state before that state changes.
REQ-003 SHALL have parameter DEPTH, default 8, power of 2, range 2..16: FIFO entries.
REQ-004 sysclock  in  1  system clock; all state changes on its rising edge.
REQ-005 sysreset_  in  1  reset, asynchronous, active-low.
REQ-006 buttons  in  8  raw key bitmap from the TM1638 driver; bit 0 = leftmost; 1 = pressed; asynchronous to the tick.
REQ-007 rd_strobe  in  1  one-cycle pop request from the CPU bus.
REQ-008 clr_ovf  in  1  one-cycle clear of the overflow flag.
REQ-009 rd_data  out  8  head entry: [7]=valid (FIFO not empty), [6]=1 press / 0 release, [5:3]=0, [2:0]=key index.
REQ-010 count  out  5  number of entries in the FIFO, 0..DEPTH.
REQ-011 overflow  out  1  sticky flag: an event was dropped.
REQ-012 irq  out  1  level output, 1 while count != 0.

Function
REQ-013 Input sync: buttons SHALL pass through a 2-flop synchronizer before use.
REQ-014 Prescaler: SHALL count 0..SYSCLK_MHZ*1000-1, wrap to 0, and assert a one-clock tick on wrap.
REQ-015 Debounce counter, per key: on each tick, +1 if synced input != debounced state, else cleared to 0.
REQ-016 Debounce commit: when a key's counter reaches DEBOUNCE_MS, its debounced bit SHALL toggle, its counter SHALL clear, and its pending bit SHALL set.
REQ-017 A glitch shorter than DEBOUNCE_MS ticks SHALL produce no event.
REQ-018 Event serializer: each clock with any pending bit set, SHALL select the lowest-index pending key.
REQ-019 Selected key: SHALL form {press = current debounced bit, index}, attempt one FIFO push, and clear that pending bit that clock.
REQ-020 Simultaneous commits on several keys SHALL emit events in ascending index order, one per clock.
REQ-021 If a key's pending bit is set again before it is serviced, only one event SHALL be emitted, with its latest state.
REQ-022 FIFO: circular buffer with write and read pointers of log2(DEPTH) bits; pointers wrap modulo DEPTH.
REQ-023 FIFO: count SHALL be a separate counter.
REQ-024 Push when count < DEPTH: write the event at the write pointer, increment the write pointer and count.
REQ-025 Push when count == DEPTH with no pop that cycle: drop the event, set overflow, leave pointers unchanged.
REQ-026 rd_strobe when count != 0: increment the read pointer, decrement count.
REQ-027 rd_strobe when count == 0: ignored; no pointer or count change and no flag.
REQ-028 Push and pop in the same cycle, count between 1 and DEPTH inclusive: both SHALL succeed and count is unchanged; this includes the full case, which SHALL NOT drop.
REQ-029 Push and pop in the same cycle with count == 0: the push SHALL succeed and the pop SHALL be ignored.
REQ-030 rd_data is first-word-fall-through: combinational from the head entry and count; rd_data = 8'h00 when empty.
REQ-031 After a pop, the next entry SHALL appear on rd_data the following cycle.
REQ-032 overflow clear: SHALL clear on clr_ovf; if a drop occurs in the same cycle, the set SHALL win.
REQ-033 Latency: a key change stable from tick N SHALL appear in the FIFO at most DEBOUNCE_MS ticks + 3 clocks after the tick where its counter reaches DEBOUNCE_MS; reset mid-key-hold restarts this interval.

Reset
REQ-034 On sysreset_ low, immediately and independent of the clock, the following SHALL clear: prescaler, all debounce counters, debounced state (all released), pending bits, synchronizer flops, pointers, count, and overflow.
REQ-035 During reset, outputs SHALL read rd_data=8'h00, count=0, overflow=0, irq=0.
REQ-036 FIFO storage contents need not reset.
REQ-037 Reset release SHALL be synchronized inside the block, and the first tick SHALL occur a full tick period after release.
REQ-038 A key held through reset SHALL produce a press event DEBOUNCE_MS ticks after release.

Verification (SYSCLK_MHZ=1, DEBOUNCE_MS=3, DEPTH=4)
REQ-039 Press key 2 and hold 5 ms -> one entry rd_data=8'hC2, irq=1, count=1; releasing and holding 5 ms -> 8'h82 queued behind it.
REQ-040 Key 5 bounce: 1 ms high, 1 ms low, repeated 4 times, then low -> count stays 0, no event.
REQ-041 buttons 8'h00 -> 8'h91 in one step, held -> events C0, C4, C7 pushed on 3 consecutive clocks, count=3.
REQ-042 Fill to 4 entries, then one more event -> dropped, overflow=1, count=4.
REQ-043 After REQ-042: push coinciding with rd_strobe -> count stays 4, no further drop; then clr_ovf -> overflow=0.
REQ-044 rd_strobe while empty -> count stays 0; then assert sysreset_ low mid-debounce with 2 entries queued -> count=0, rd_data=8'h00 immediately.

Source files
------------

// File: rtl/key_event_queue.sv
// key_event_queue: debounces the TM1638 key bitmap, serializes press/release
// edges into event codes and queues them in a small FIFO for the CPU.
module key_event_queue #(
    parameter int unsigned SYSCLK_MHZ  = 50,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned DEPTH       = 8
) (
    input  logic       sysclock,
    input  logic       sysreset_,
    input  logic [7:0] buttons,
    input  logic       rd_strobe,
    input  logic       clr_ovf,
    output logic [7:0] rd_data,
    output logic [4:0] count,
    output logic       overflow,
    output logic       irq
);

    localparam int unsigned NKEYS     = 8;
    localparam int unsigned TICK_CLKS = SYSCLK_MHZ * 1000;
    localparam int unsigned PRE_W     = $clog2(TICK_CLKS);
    localparam int unsigned DB_W      = 4;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned EV_W      = 4;

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [NKEYS-1:0] btn_meta;
    logic [NKEYS-1:0] btn_sync;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick_c;
    logic [DB_W-1:0]  db_cnt [NKEYS];
    logic [NKEYS-1:0] db_state;
    logic [NKEYS-1:0] diff_c;
    logic [NKEYS-1:0] commit_c;
    logic [NKEYS-1:0] pending;
    logic [2:0]       sel_idx_c;
    logic [NKEYS-1:0] sel_mask_c;
    logic             ev_valid_c;
    logic [EV_W-1:0]  ev_data_c;
    logic [EV_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [EV_W-1:0]  head_c;
    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge sysclock or negedge sysreset_) begin
        if (!sysreset_) rst_sync <= '0;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Two-flop synchronizer for the raw key bitmap.
    always_ff @(posedge sysclock or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= buttons;
            btn_sync <= btn_meta;
        end
    end

    // 1 ms prescaler; tick is high during the last count before wrap.
    always_ff @(posedge sysclock or negedge rst_n) begin
        if (!rst_n)      pre_cnt <= '0;
        else if (tick_c) pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + PRE_W'(1);
    end

    assign tick_c = (pre_cnt == PRE_W'(TICK_CLKS - 1));

    // Per-key commit decision: counter about to reach DEBOUNCE_MS on a tick.
    always_comb begin
        diff_c   = btn_sync ^ db_state;
        commit_c = '0;
        for (int i = 0; i < NKEYS; i++) begin
            commit_c[i] = tick_c && diff_c[i] &&
                          (db_cnt[i] == DB_W'(DEBOUNCE_MS - 1));
        end
    end

    // Debounce counters and debounced state.
    always_ff @(posedge sysclock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NKEYS; i++) db_cnt[i] <= '0;
            db_state <= '0;
        end else begin
            if (tick_c) begin
                for (int i = 0; i < NKEYS; i++) begin
                    if (!diff_c[i] || commit_c[i]) db_cnt[i] <= '0;
                    else                           db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
            db_state <= db_state ^ commit_c;
        end
    end

    // Lowest-index pending key becomes this cycle's event.
    always_comb begin
        sel_idx_c = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pending[i]) sel_idx_c = 3'(i);
        end
        ev_valid_c = |pending;
        sel_mask_c = ev_valid_c ? (NKEYS'(1) << sel_idx_c) : '0;
        ev_data_c  = {db_state[sel_idx_c], sel_idx_c};
    end

    // Pending bits: a fresh commit wins over the service clear.
    always_ff @(posedge sysclock or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= (pending & ~sel_mask_c) | commit_c;
    end

    // FIFO control; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        empty_c = (count == '0);
        full_c  = (count == CNT_W'(DEPTH));
        pop_c   = rd_strobe && !empty_c;
        push_c  = ev_valid_c && (!full_c || pop_c);
        drop_c  = ev_valid_c && full_c && !pop_c;
    end

    // FIFO pointers, occupancy counter and sticky overflow.
    always_ff @(posedge sysclock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      count <= count + CNT_W'(1);
            else if (pop_c && !push_c) count <= count - CNT_W'(1);
            if (drop_c)       overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge sysclock) begin
        if (push_c) mem[wr_ptr] <= ev_data_c;
    end

    // First-word-fall-through head presentation.
    always_comb begin
        head_c  = mem[rd_ptr];
        rd_data = empty_c ? 8'h00 : {1'b1, head_c[3], 3'b000, head_c[2:0]};
        irq     = !empty_c;
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Testbench for key_event_queue (SYSCLK_MHZ=1, DEBOUNCE_MS=3, DEPTH=4).
module tb_key_event_queue;

    localparam int unsigned TICK = 1000;
    localparam int unsigned DB   = 3;
    localparam int unsigned DEP  = 4;

    logic       sysclock = 1'b0;
    logic       sysreset_ = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic       rd_strobe = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       overflow;
    logic       irq;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int base = 0;
    int p_edge = 0;

    typedef struct {
        logic [7:0] btn;
        int         pops;
        logic [4:0] exp_count;
        logic [7:0] exp_head;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: keys sampled once per 1 ms tick.
    logic [7:0] m_db;
    int         m_run [8];
    logic [7:0] m_q[$];
    logic       m_ovf;

    key_event_queue #(.SYSCLK_MHZ(1), .DEBOUNCE_MS(DB), .DEPTH(DEP)) dut (
        .sysclock (sysclock),
        .sysreset_(sysreset_),
        .buttons  (buttons),
        .rd_strobe(rd_strobe),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow),
        .irq      (irq)
    );

    always #5 sysclock = ~sysclock;

    always @(posedge sysclock) cyc <= cyc + 1;

    initial begin
        #(10 * 150_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [7:0] b, input int p, input logic [4:0] c,
                                input logic [7:0] h, input logic o);
        vec_t v;
        v.btn = b; v.pops = p; v.exp_count = c; v.exp_head = h; v.exp_ovf = o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic to_mid();
        @(negedge sysclock);
        while (((cyc - base) % TICK) != 500) @(negedge sysclock);
    endtask

    task automatic pop1();
        rd_strobe = 1'b1;
        @(negedge sysclock);
        rd_strobe = 1'b0;
    endtask

    task automatic check_out(input string nm, input logic [4:0] c, input logic [7:0] h,
                             input logic o);
        chk({nm, "_count"}, 32'(count), 32'(c));
        chk({nm, "_rd_data"}, 32'(rd_data), 32'(h));
        chk({nm, "_overflow"}, 32'(overflow), 32'(o));
        chk({nm, "_irq"}, 32'(irq), 32'(c != 0));
    endtask

    task automatic step(input vec_t v, input string nm);
        for (int k = 0; k < v.pops; k++) pop1();
        buttons = v.btn;
        to_mid();
        check_out(nm, v.exp_count, v.exp_head, v.exp_ovf);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) step(tbl[i], $sformatf("row%0d", i));
    endtask

    task automatic do_reset(input logic [7:0] b);
        sysreset_ = 1'b0;
        buttons = b;
        repeat (3) @(negedge sysclock);
        check_out("reset", 5'd0, 8'h00, 1'b0);
        sysreset_ = 1'b1;
        base = cyc;
        m_db = '0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_q.delete();
        m_ovf = 1'b0;
        to_mid();
    endtask

    // One tick of the reference rules; events land in an empty 4-entry queue.
    task automatic model_tick(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (b[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == int'(DB)) begin
                    m_db[i] = b[i];
                    m_run[i] = 0;
                    if (m_q.size() < int'(DEP)) m_q.push_back({1'b1, b[i], 3'b000, 3'(i)});
                    else m_ovf = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] exp_drain [4];
        bit         found;
        int         target;

        // rows 0-10: key 2 press then release
        tbl.push_back(mk(8'h04, 0, 0, 8'h00, 0));
        tbl.push_back(mk(8'h04, 0, 0, 8'h00, 0));
        tbl.push_back(mk(8'h04, 0, 1, 8'hC2, 0));
        tbl.push_back(mk(8'h04, 0, 1, 8'hC2, 0));
        tbl.push_back(mk(8'h04, 0, 1, 8'hC2, 0));
        tbl.push_back(mk(8'h00, 0, 1, 8'hC2, 0));
        tbl.push_back(mk(8'h00, 0, 1, 8'hC2, 0));
        tbl.push_back(mk(8'h00, 0, 2, 8'hC2, 0));
        tbl.push_back(mk(8'h00, 0, 2, 8'hC2, 0));
        tbl.push_back(mk(8'h00, 1, 1, 8'h82, 0));
        tbl.push_back(mk(8'h00, 1, 0, 8'h00, 0));
        // rows 11-20: key 5 bounce, no event
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(8'h20, 0, 0, 8'h00, 0));
            tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0));
        end
        tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0));
        tbl.push_back(mk(8'h00, 0, 0, 8'h00, 0));
        // rows 21-22: multi-key press, first two ticks
        tbl.push_back(mk(8'h91, 0, 0, 8'h00, 0));
        tbl.push_back(mk(8'h91, 0, 0, 8'h00, 0));
        // rows 23-25: drain in ascending key order
        tbl.push_back(mk(8'h91, 1, 2, 8'hC4, 0));
        tbl.push_back(mk(8'h91, 1, 1, 8'hC7, 0));
        tbl.push_back(mk(8'h91, 1, 0, 8'h00, 0));
        // rows 26-31: fill to 4 then drop one
        tbl.push_back(mk(8'h1F, 0, 0, 8'h00, 0));
        tbl.push_back(mk(8'h1F, 0, 0, 8'h00, 0));
        tbl.push_back(mk(8'h1F, 0, 4, 8'hC1, 0));
        tbl.push_back(mk(8'h1E, 0, 4, 8'hC1, 0));
        tbl.push_back(mk(8'h1E, 0, 4, 8'hC1, 0));
        tbl.push_back(mk(8'h1E, 0, 4, 8'hC1, 1));

        do_reset(8'h00);
        run_rows(0, 22);

        // Three simultaneous commits push on consecutive clocks.
        found = 0;
        for (int k = 0; k < 1100 && !found; k++) begin
            @(negedge sysclock);
            if (count != 0) begin
                found = 1;
                p_edge = cyc;
            end
        end
        chk("multi_first_push_seen", 32'(found), 32'd1);
        check_out("multi_c1", 5'd1, 8'hC0, 1'b0);
        @(negedge sysclock);
        check_out("multi_c2", 5'd2, 8'hC0, 1'b0);
        @(negedge sysclock);
        check_out("multi_c3", 5'd3, 8'hC0, 1'b0);
        to_mid();

        run_rows(23, 31);

        // Push on a full FIFO coinciding with a pop must not drop.
        buttons = 8'h1C;
        to_mid();
        check_out("full_hold1", 5'd4, 8'hC1, 1'b1);
        to_mid();
        check_out("full_hold2", 5'd4, 8'hC1, 1'b1);
        target = p_edge + ((cyc - p_edge) / int'(TICK) + 1) * int'(TICK);
        for (int k = 0; k < 1100 && cyc != target - 1; k++) @(negedge sysclock);
        chk("full_align", 32'(cyc), 32'(target - 1));
        pop1();
        check_out("full_pushpop", 5'd4, 8'hC2, 1'b1);
        clr_ovf = 1'b1;
        @(negedge sysclock);
        clr_ovf = 1'b0;
        check_out("clr_ovf", 5'd4, 8'hC2, 1'b0);
        exp_drain[0] = 8'hC2; exp_drain[1] = 8'hC3; exp_drain[2] = 8'h87; exp_drain[3] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), 32'(rd_data), 32'(exp_drain[i]));
            pop1();
        end
        check_out("drained", 5'd0, 8'h00, 1'b0);

        // Randomized key patterns against the tick-level model.
        do_reset(8'h00);
        b = 8'h00;
        for (int s = 0; s < 16; s++) begin
            if ($urandom_range(0, 1) == 1) b = b ^ 8'($urandom);
            buttons = b;
            model_tick(b);
            to_mid();
            check_out($sformatf("rnd%0d", s), 5'(m_q.size()),
                      (m_q.size() != 0) ? m_q[0] : 8'h00, m_ovf);
            while (m_q.size() != 0) begin
                chk($sformatf("rnd%0d_pop", s), 32'(rd_data), 32'(m_q[0]));
                void'(m_q.pop_front());
                pop1();
            end
            chk($sformatf("rnd%0d_empty", s), 32'(count), 32'd0);
            if (m_ovf) begin
                clr_ovf = 1'b1;
                @(negedge sysclock);
                clr_ovf = 1'b0;
                m_ovf = 1'b0;
            end
        end

        // Pop while empty is ignored; reset mid-debounce clears at once.
        do_reset(8'h00);
        pop1();
        check_out("pop_empty", 5'd0, 8'h00, 1'b0);
        step(mk(8'h03, 0, 0, 8'h00, 0), "pre_rst0");
        step(mk(8'h03, 0, 0, 8'h00, 0), "pre_rst1");
        step(mk(8'h03, 0, 2, 8'hC0, 0), "pre_rst2");
        step(mk(8'h83, 0, 2, 8'hC0, 0), "pre_rst3");
        #2;
        sysreset_ = 1'b0;
        #1;
        check_out("async_reset", 5'd0, 8'h00, 1'b0);
        repeat (3) @(negedge sysclock);
        check_out("in_reset", 5'd0, 8'h00, 1'b0);
        sysreset_ = 1'b1;
        base = cyc;
        to_mid();
        step(mk(8'h83, 0, 0, 8'h00, 0), "held0");
        step(mk(8'h83, 0, 0, 8'h00, 0), "held1");
        step(mk(8'h83, 0, 3, 8'hC0, 0), "held2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
